phase_nco: RTL and testbench

PHASE_NCO -- requirements
Module: phase_nco

---
 rtl/phase_nco.sv | 170 +++++++++++++++++
 tb/tb_phase_nco.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_nco.sv
// phase_nco: phase-accumulator NCO, 3-stage pipeline with a quarter-wave sine LUT and valid/ready output.
// Optional macro PHASE_NCO_DITHER_EN adds LFSR phase dither ahead of LUT index truncation.
module phase_nco #(
  parameter int PHASE_W = 24,
  parameter int DATA_W  = 12
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic               enable,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic               ph_clr,
  input  logic [PHASE_W-1:0] phase_offset,
  output logic [DATA_W-1:0]  ph_out_M_real_V,
  output logic [DATA_W-1:0]  ph_out_M_imag_V,
  output logic               out_vld,
  input  logic               out_rdy
);

  localparam logic signed [127:0] PI_Q48 = 128'sh3243F6A8885A3;

  // T[k] = round(2047*sin(pi*(2k+1)/1024)) evaluated at elaboration with a Q48 Taylor series.
  function automatic logic [10:0] lut_val(input int k);
    logic signed [127:0] x;
    logic signed [127:0] term;
    logic signed [127:0] sum;
    x    = (PI_Q48 * 128'(2 * k + 1)) >>> 10;
    term = x;
    sum  = x;
    for (int n = 1; n <= 12; n++) begin
      term = (term * x) >>> 48;
      term = (term * x) >>> 48;
      term = -(term / 128'(2 * n * (2 * n + 1)));
      sum  = sum + term;
    end
    sum = (sum * 128'sd2047 + (128'sd1 <<< 47)) >>> 48;
    return sum[10:0];
  endfunction

  logic [10:0] lut [256];
  for (genvar k = 0; k < 256; k++) begin : g_lut
    localparam logic [10:0] LUT_V = lut_val(k);
    assign lut[k] = LUT_V;
  end

  logic               stall;
  logic               issue;
  logic [PHASE_W-1:0] lut_phase;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic               s0_vld_q, s0_vld_d;
  logic [9:0]         s0_idx_q, s0_idx_d;
  logic               s1_vld_q, s1_vld_d;
  logic [1:0]         s1_quad_q, s1_quad_d;
  logic [10:0]        s1_ta_q, s1_ta_d;
  logic [10:0]        s1_tb_q, s1_tb_d;
  logic               out_vld_q, out_vld_d;
  logic [DATA_W-1:0]  re_q, re_d;
  logic [DATA_W-1:0]  im_q, im_d;
  logic [DATA_W-1:0]  mag_a;
  logic [DATA_W-1:0]  mag_b;

  assign stall = out_vld_q & ~out_rdy;
  assign issue = ~stall & enable;

`ifdef PHASE_NCO_DITHER_EN
  localparam int DITH_W = (PHASE_W - 10 < 16) ? PHASE_W - 10 : 16;
  logic [15:0] lfsr_q, lfsr_d;

  // LFSR x^16+x^14+x^13+x^11+1 steps once per issued sample
  always_comb begin
    lfsr_d = lfsr_q;
    if (issue) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR state register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lut_phase = acc_q + PHASE_W'(lfsr_q[DITH_W-1:0]);
`else
  assign lut_phase = acc_q;
`endif

  assign mag_a = DATA_W'(s1_ta_q);
  assign mag_b = DATA_W'(s1_tb_q);

  // Accumulator update and pipeline advance; clear wins over increment and ignores stall
  always_comb begin
    acc_d     = acc_q;
    s0_vld_d  = s0_vld_q;
    s0_idx_d  = s0_idx_q;
    s1_vld_d  = s1_vld_q;
    s1_quad_d = s1_quad_q;
    s1_ta_d   = s1_ta_q;
    s1_tb_d   = s1_tb_q;
    out_vld_d = out_vld_q;
    re_d      = re_q;
    im_d      = im_q;
    if (ph_clr) begin
      acc_d = phase_offset;
    end else if (issue) begin
      acc_d = acc_q + freq_word;
    end else begin
      acc_d = acc_q;
    end
    if (!stall) begin
      s0_vld_d  = enable;
      s0_idx_d  = 10'(lut_phase >> (PHASE_W - 10));
      s1_vld_d  = s0_vld_q;
      s1_quad_d = s0_idx_q[9:8];
      s1_ta_d   = lut[s0_idx_q[7:0]];
      s1_tb_d   = lut[~s0_idx_q[7:0]];
      out_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        case (s1_quad_q)
          2'd0:    begin re_d = mag_b;  im_d = mag_a;  end
          2'd1:    begin re_d = -mag_a; im_d = mag_b;  end
          2'd2:    begin re_d = -mag_b; im_d = -mag_a; end
          2'd3:    begin re_d = mag_a;  im_d = -mag_b; end
          default: begin re_d = mag_b;  im_d = mag_a;  end
        endcase
      end else begin
        re_d = re_q;
        im_d = im_q;
      end
    end else begin
      out_vld_d = out_vld_q;
    end
  end

  // Pipeline and accumulator registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q     <= '0;
      s0_vld_q  <= 1'b0;
      s0_idx_q  <= '0;
      s1_vld_q  <= 1'b0;
      s1_quad_q <= '0;
      s1_ta_q   <= '0;
      s1_tb_q   <= '0;
      out_vld_q <= 1'b0;
      re_q      <= '0;
      im_q      <= '0;
    end else begin
      acc_q     <= acc_d;
      s0_vld_q  <= s0_vld_d;
      s0_idx_q  <= s0_idx_d;
      s1_vld_q  <= s1_vld_d;
      s1_quad_q <= s1_quad_d;
      s1_ta_q   <= s1_ta_d;
      s1_tb_q   <= s1_tb_d;
      out_vld_q <= out_vld_d;
      re_q      <= re_d;
      im_q      <= im_d;
    end
  end

  assign ph_out_M_real_V = re_q;
  assign ph_out_M_imag_V = im_q;
  assign out_vld         = out_vld_q;

endmodule

// File: tb/tb_phase_nco.sv
// tb_phase_nco: randomized and directed self-checking bench for phase_nco (default, undithered build).
module tb_phase_nco;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        ph_clr;
  logic        out_rdy;
  logic [23:0] freq_word;
  logic [23:0] phase_offset;
  logic [11:0] re;
  logic [11:0] im;
  logic        vld;

  int n_chk  = 0;
  int n_fail = 0;

  int          tbl [256];
  logic [23:0] m_acc;
  logic [23:0] q_ph [$];
  int          q_age [$];
  int          cap_re [$];
  int          cap_im [$];

  always #5 clk = ~clk;

  phase_nco dut (
    .ap_clk          (clk),
    .ap_rst_n        (rst_n),
    .enable          (enable),
    .freq_word       (freq_word),
    .ph_clr          (ph_clr),
    .phase_offset    (phase_offset),
    .ph_out_M_real_V (re),
    .ph_out_M_imag_V (im),
    .out_vld         (vld),
    .out_rdy         (out_rdy)
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Expected (cos, sin) for an accumulator phase, from the quadrant rules
  task automatic exp_iq(input logic [23:0] p, output int c, output int s);
    int i, q, a;
    i = int'(p[23:14]);
    q = i / 256;
    a = i % 256;
    case (q)
      0:       begin c = tbl[255 - a];  s = tbl[a];        end
      1:       begin c = -tbl[a];       s = tbl[255 - a];  end
      2:       begin c = -tbl[255 - a]; s = -tbl[a];       end
      default: begin c = tbl[a];        s = -tbl[255 - a]; end
    endcase
  endtask

  task automatic model_clear();
    m_acc = 24'd0;
    q_ph.delete();
    q_age.delete();
    cap_re.delete();
    cap_im.delete();
  endtask

  // Scoreboard of in-flight samples: each issued sample is seen 3 unstalled edges later
  task automatic model_edge();
    bit head_out;
    head_out = (q_age.size() > 0) && (q_age[0] == 3);
    if (!(head_out && !out_rdy)) begin
      if (head_out) begin
        cap_re.push_back(int'($signed(re)));
        cap_im.push_back(int'($signed(im)));
        void'(q_ph.pop_front());
        void'(q_age.pop_front());
      end
      foreach (q_age[i]) q_age[i] = q_age[i] + 1;
      if (enable) begin
        q_ph.push_back(m_acc);
        q_age.push_back(1);
        m_acc = m_acc + freq_word;
      end
    end
    if (ph_clr) m_acc = phase_offset;
  endtask

  task automatic check_out();
    bit ev;
    int c, s;
    ev = (q_age.size() > 0) && (q_age[0] == 3);
    check("out_vld", vld, ev);
    if (ev) begin
      exp_iq(q_ph[0], c, s);
      check("real", $signed(re), c);
      check("imag", $signed(im), s);
    end
  endtask

  task automatic step(input logic en, input logic clr, input logic rdy);
    enable  = en;
    ph_clr  = clr;
    out_rdy = rdy;
    model_edge();
    @(negedge clk);
    check_out();
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    enable       = 1'b0;
    ph_clr       = 1'b0;
    out_rdy      = 1'b1;
    freq_word    = 24'd0;
    phase_offset = 24'd0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until(input int n, input int budget);
    for (int c = 0; c < budget && cap_re.size() < n; c++) step(1'b1, 1'b0, 1'b1);
    check("sample_count_reached", cap_re.size() >= n, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int first, c5, s5;
    for (int k = 0; k < 256; k++)
      tbl[k] = int'($floor(2047.0 * $sin(3.141592653589793 * (real'(k) + 0.5) / 512.0) + 0.5));

    // Reset state, first-sample latency, 64-sample period
    do_reset();
    check("rst_vld", vld, 0);
    check("rst_real", $signed(re), 0);
    check("rst_imag", $signed(im), 0);
    freq_word = 24'd262144;
    first = -1;
    for (int c = 1; c <= 10; c++) begin
      step(1'b1, 1'b0, 1'b1);
      if (vld && first < 0) first = c;
    end
    check("first_vld_cycle", first, 3);
    run_until(70, 200);
    check("s0_real", cap_re[0], 2047);
    check("s0_imag", cap_im[0], 6);
    check("s16_real", cap_re[16], -6);
    check("s16_imag", cap_im[16], 2047);
    check("s32_real", cap_re[32], -2047);
    check("s48_imag", cap_im[48], -2047);
    check("s64_real", cap_re[64], 2047);
    check("s64_imag", cap_im[64], 6);

    // Ten-cycle backpressure with a clear landing mid-stall
    phase_offset = 24'h123456;
    for (int c = 0; c < 10; c++) step(1'b1, (c == 5) ? 1'b1 : 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) step(1'b1, 1'b0, 1'b1);

    // Half-rate tone alternates between two points
    do_reset();
    freq_word = 24'h800000;
    run_until(6, 30);
    check("alt0_real", cap_re[0], 2047);
    check("alt0_imag", cap_im[0], 6);
    check("alt1_real", cap_re[1], -2047);
    check("alt1_imag", cap_im[1], -6);
    check("alt2_real", cap_re[2], 2047);
    check("alt3_imag", cap_im[3], -6);

    // Clear concurrent with an advance: old phase issued, then offset
    do_reset();
    freq_word    = 24'd262144;
    phase_offset = 24'h400000;
    for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    run_until(8, 30);
    exp_iq(24'd1310720, c5, s5);
    check("clr_old_real", cap_re[5], c5);
    check("clr_old_imag", cap_im[5], s5);
    check("clr_new_real", cap_re[6], -6);
    check("clr_new_imag", cap_im[6], 2047);

    // Asynchronous reset with three samples in flight
    do_reset();
    freq_word = 24'd262144;
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_vld", vld, 0);
    check("async_rst_real", $signed(re), 0);
    check("async_rst_imag", $signed(im), 0);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b1);
    first = -1;
    for (int c = 1; c <= 10; c++) begin
      step(1'b1, 1'b0, 1'b1);
      if (vld && first < 0) first = c;
    end
    check("post_rst_first_cycle", first, 3);
    check("post_rst_s0_real", cap_re[0], 2047);
    check("post_rst_s0_imag", cap_im[0], 6);

    // Randomized enable / ready / clear / frequency traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) freq_word = 24'($urandom);
      if ($urandom_range(0, 9) == 0) phase_offset = 24'($urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0);
    end

    // Near-full-scale increment exercises accumulator wrap
    do_reset();
    freq_word = 24'hFFFFFF;
    run_until(1000, 1100);
    check("wrap1_real", cap_re[1], 2047);
    check("wrap1_imag", cap_im[1], -6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
